// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// One multiplier/quotient bit per cycle, then a sign-fix cycle that commits HI/LO.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             startE,
    input  logic [2:0]       opE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             kill,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             divzero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t             r_state, w_state_next;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_opb;      // multiplicand for MUL, divisor for DIV
    logic [2*WIDTH-1:0] r_acc;      // {partial/remainder, multiplier/quotient}
    logic [WIDTH-1:0]   r_raw_a;
    logic [WIDTH-1:0]   r_hi, r_lo;
    logic               r_is_div, r_neg_q, r_neg_r, r_dz;
    logic               r_done, r_divzero;

    logic               w_start, w_signed, w_last;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_div_rem, w_div_diff;
    logic               w_div_ok;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot, w_rem;

    assign w_start  = startE && !kill && (r_state == S_IDLE);
    assign w_signed = ~opE[0];
    assign w_last   = (r_cnt == CW'(WIDTH - 1));
    assign w_mag_a  = (w_signed && srcaE[WIDTH-1]) ? -srcaE : srcaE;
    assign w_mag_b  = (w_signed && srcbE[WIDTH-1]) ? -srcbE : srcbE;

    // Shift-add: add multiplicand into the upper half when the current LSB is set.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opb : {WIDTH{1'b0}})};
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring division: a set borrow bit means the trial subtraction went negative.
    assign w_div_rem  = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_diff = w_div_rem - {1'b0, r_opb};
    assign w_div_ok   = ~w_div_diff[WIDTH];
    assign w_div_next = {(w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_rem[WIDTH-1:0]),
                         r_acc[WIDTH-2:0], w_div_ok};

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quot = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start && !opE[2]) w_state_next = opE[1] ? S_DIV : S_MUL;
            S_MUL:   if (w_last) w_state_next = S_FIX;
            S_DIV:   if (w_last) w_state_next = S_FIX;
            S_FIX:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (kill) w_state_next = S_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_opb     <= '0;
            r_acc     <= '0;
            r_raw_a   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_is_div  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dz      <= 1'b0;
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        case (opE)
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                r_cnt    <= '0;
                                r_opb    <= w_mag_b;
                                r_acc    <= {{WIDTH{1'b0}}, w_mag_a};
                                r_raw_a  <= srcaE;
                                r_is_div <= opE[1];
                                r_neg_q  <= w_signed & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
                                r_neg_r  <= w_signed & srcaE[WIDTH-1];
                                r_dz     <= opE[1] && (srcbE == '0);
                            end
                            3'b100:  r_hi <= srcaE;
                            3'b101:  r_lo <= srcaE;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (!kill) begin
                        r_acc <= w_mul_next;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DIV: begin
                    if (!kill) begin
                        r_acc <= w_div_next;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FIX: begin
                    if (!kill) begin
                        r_done <= 1'b1;
                        if (!r_is_div) begin
                            r_hi <= w_prod[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod[WIDTH-1:0];
                        end else if (r_dz) begin
                            // Divide by zero reports the original dividend, not its magnitude.
                            r_hi      <= r_raw_a;
                            r_lo      <= {WIDTH{1'b1}};
                            r_divzero <= 1'b1;
                        end else begin
                            r_hi <= w_rem;
                            r_lo <= w_quot;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi      = r_hi;
    assign lo      = r_lo;
    assign busy    = (r_state != S_IDLE);
    assign done    = r_done;
    assign divzero = r_divzero;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32): latency, results, MTHI/MTLO, kill and reset.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        startE;
    logic [2:0]  opE;
    logic [31:0] srcaE, srcbE;
    logic        kill;
    logic [31:0] hi, lo;
    logic        busy, done, divzero;

    int n_checks = 0;
    int n_err    = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .startE(startE), .opE(opE),
        .srcaE(srcaE), .srcbE(srcbE), .kill(kill),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .divzero(divzero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue a mul/div; returns at the negedge of the done cycle.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edz, input logic b2b);
        int n;
        if (!b2b) begin
            @(negedge clk);
            chk({tag, "_done_fall"}, 64'(done), 64'd0);
        end
        startE = 1'b1; opE = op; srcaE = a; srcbE = b;
        @(negedge clk);
        startE = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, 64'(n), 64'd33);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_divzero"}, 64'(divzero), 64'(edz));
        chk({tag, "_hi"}, 64'(hi), 64'(ehi));
        chk({tag, "_lo"}, 64'(lo), 64'(elo));
        $display("op %s a=%h b=%h -> hi=%h lo=%h done=%b dz=%b cycles=%0d", tag, a, b, hi, lo, done, divzero, n);
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] d, input logic k);
        @(negedge clk);
        startE = 1'b1; opE = op; srcaE = d; kill = k;
        @(negedge clk);
        startE = 1'b0; kill = 1'b0;
        $display("mt op=%b data=%h kill=%b -> hi=%h lo=%h", op, d, k, hi, lo);
    endtask

    initial begin
        reset = 1'b1; startE = 1'b0; kill = 1'b0; opE = 3'b000; srcaE = '0; srcbE = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_divzero", 64'(divzero), 64'd0);

        // Asynchronous reset mid-operation clears HI/LO without a clock edge.
        mt(3'b100, 32'hA5A5_A5A5, 1'b0);
        chk("mthi_a5", 64'(hi), 64'hA5A5_A5A5);
        @(negedge clk);
        startE = 1'b1; opE = 3'b001; srcaE = 32'd3; srcbE = 32'd4;
        @(negedge clk);
        startE = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_hi", 64'(hi), 64'd0);
        chk("async_rst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_done", 64'(done), 64'd0);
        $display("reset sequence hi=%h lo=%h busy=%b", hi, lo, busy);

        run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
        run_op("mult_m3x5", 3'b000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b0);

        mt(3'b100, 32'h1234_5678, 1'b0);
        chk("mthi_hi", 64'(hi), 64'h1234_5678);
        chk("mthi_lo", 64'(lo), 64'hFFFF_FFF1);
        chk("mthi_busy", 64'(busy), 64'd0);
        chk("mthi_done", 64'(done), 64'd0);

        mt(3'b101, 32'hDEAD_BEEF, 1'b1);
        chk("mtlo_killed_lo", 64'(lo), 64'hFFFF_FFF1);
        mt(3'b101, 32'h0BAD_F00D, 1'b0);
        chk("mtlo_lo", 64'(lo), 64'h0BAD_F00D);
        chk("mtlo_hi", 64'(hi), 64'h1234_5678);

        run_op("div_m7d2", 3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
        run_op("div_min_m1", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 1'b1);
        run_op("divu_100d0", 3'b011, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op("div_m5d0", 3'b010, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1'b0);

        // Kill in busy cycle 10, then reissue in the very next cycle.
        @(negedge clk);
        startE = 1'b1; opE = 3'b011; srcaE = 32'd100; srcbE = 32'd7;
        @(negedge clk);
        startE = 1'b0;
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("kill_busy", 64'(busy), 64'd0);
        chk("kill_done", 64'(done), 64'd0);
        chk("kill_hi", 64'(hi), 64'hFFFF_FFFB);
        chk("kill_lo", 64'(lo), 64'hFFFF_FFFF);
        $display("kill at busy cycle 10 -> busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
        run_op("divu_100d7", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1);

        run_op("mult_min_m1", 3'b000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 1'b0);
        run_op("mult_7xm9", 3'b000, 32'd7, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 32'hFFFF_FFC1, 1'b0, 1'b1);
        @(negedge clk);
        chk("final_done_fall", 64'(done), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit attached to the EX stage of the pipelined MIPS core, adding MULT/MULTU/DIV/DIVU and the HI/LO register pair the current core lacks. Operations are issued from EX with a one-cycle start pulse. The unit computes one bit per cycle and raises `busy` so the hazard unit can stall dependent MFHI/MFLO and new mul/div issues. An exception flush can abort an in-flight operation without disturbing architectural HI/LO.

## Interface
Parameters:
- `WIDTH`, 32, operand/HI/LO width (≥4, even)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `startE`  in  1  issue strobe, sampled only while `busy`=0
- `opE`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
- `srcaE`  in  WIDTH  rs operand (dividend / multiplicand / MTxx data)
- `srcbE`  in  WIDTH  rt operand (divisor / multiplier)
- `kill`  in  1  abort in-flight op (exception flush)
- `hi`, `lo`  out  WIDTH  architectural HI/LO
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle pulse: HI/LO just updated by mul/div
- `divzero`  out  1  accompanies `done` when divisor was zero

## Operation
- States: IDLE, MUL, DIV, FIX. Reset: IDLE, `hi`=`lo`=0, `busy`=`done`=`divzero`=0, counter 0.
- IDLE + `startE` + op MULT/MULTU: latch |a|,|b| (signed ops take magnitude; unsigned use raw), record result sign = sa^sb (MULT only), go MUL.
- IDLE + `startE` + DIV/DIVU: latch magnitudes, quotient sign = sa^sb, remainder sign = sa (DIV only), go DIV.
- MTHI/MTLO: `hi`/`lo` = `srcaE` at that edge; stays IDLE; no `busy`, no `done`.
- MUL: shift-add, 2·WIDTH-bit accumulator, one multiplier bit per cycle, WIDTH iterations.
- DIV: restoring division, one quotient bit per cycle, WIDTH iterations.
- FIX (one cycle): negate product (2·WIDTH bits) or quotient/remainder per recorded signs; write {`hi`,`lo`} = product, or `lo`=quotient, `hi`=remainder; return IDLE.
- Signed overflow MIN/−1: natural result of magnitude algorithm, `lo`=MIN, `hi`=0; no flag.
- Divide by zero (either signedness): `lo`={WIDTH{1}}, `hi`=`srcaE` as latched (unsigned raw value for DIVU; original signed value for DIV); `divzero`=1 with `done`. Still takes full latency.
- `kill` in MUL/DIV/FIX: next edge → IDLE, HI/LO unchanged, no `done`. `kill` in IDLE suppresses a same-cycle `startE` (including MTHI/MTLO).
- `startE` while `busy`=1: ignored (hazard unit must stall; bench asserts it never happens).
- Reset mid-operation: immediate return to reset values; no partial HI/LO write.

## Timing
- Start sampled at edge k; `busy`=1 in cycles k+1 … k+WIDTH+1 (WIDTH+1 cycles).
- Iterations on edges k+1 … k+WIDTH; FIX writes HI/LO at edge k+WIDTH+1, `busy` falls at same edge.
- `done` (and `divzero` if applicable) high exactly the cycle after edge k+WIDTH+1.
- New start accepted in the `done` cycle (back-to-back issue, gap of 0).
- MTHI/MTLO: result visible on `hi`/`lo` cycle after the edge; 1-cycle latency.
- `hi`/`lo`/`busy`/`done`/`divzero` are registered outputs; no combinational input→output paths.

## Test plan
- Reset asserted asynchronously mid-cycle -> `hi`=`lo`=0, `busy`=0 immediately; held low after release until a start.
- MULTU 0xFFFFFFFF×0xFFFFFFFF (WIDTH=32) -> `busy` 33 cycles, then `hi`=0xFFFFFFFE, `lo`=0x00000001, `done` one cycle.
- MULT −3×5 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1; then MTHI 0x12345678 -> `hi`=0x12345678 next cycle, `lo` unchanged.
- DIV −7/2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- DIVU 100/0 -> after 33 cycles `lo`=0xFFFFFFFF, `hi`=100, `done`=`divzero`=1 same cycle.
- DIVU 100/7, `kill` at busy cycle 10 -> IDLE next cycle, `hi`/`lo` keep prior values, no `done`; immediate reissue yields `lo`=14, `hi`=2.
